// File: rtl/main_ctrl_fsm.sv
// main_ctrl_fsm: multi-cycle main control FSM (fetch/decode/execute/mem/wb)
// Ports: clk, rst_n | opcode, fun3, mem_ready in | mem/datapath controls,
//        ALUop, fault, fault_code, state_out, retired out
module main_ctrl_fsm #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       opcode,
   input  logic [2:0]       fun3,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_read,
   output logic             mem_write,
   output logic             iord,
   output logic             ir_write,
   output logic             pc_write,
   output logic             branch,
   output logic             reg_write,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       result_src,
   output logic [1:0]       ALUop,
   output logic             fault,
   output logic [1:0]       fault_code,
   output logic [3:0]       state_out,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_BEQ      = 4'd8,
      S_FAULT    = 4'd15
   } state_e;

   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;
   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TLIM =
      (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

   state_e           state_q, state_d;
   logic [TW-1:0]    wcnt_q, wcnt_d;
   logic [1:0]       fcode_q, fcode_d;
   logic [CNT_W-1:0] ret_q;
   logic             retire;
   logic             waiting;
   logic             tmo;

   logic       req_c, rd_c, wr_c, iord_c, ir_c, pc_c;
   logic       br_c, rw_c, flt_c;
   logic [1:0] a_c, b_c, rs_c, op_c;

   always_comb begin
      state_d = state_q;
      fcode_d = fcode_q;
      retire  = 1'b0;
      waiting = 1'b0;
      req_c   = 1'b0;
      rd_c    = 1'b0;
      wr_c    = 1'b0;
      iord_c  = 1'b0;
      ir_c    = 1'b0;
      pc_c    = 1'b0;
      br_c    = 1'b0;
      rw_c    = 1'b0;
      flt_c   = 1'b0;
      a_c     = 2'b00;
      b_c     = 2'b00;
      rs_c    = 2'b00;
      op_c    = 2'b00;
      unique case (state_q)
         S_FETCH: begin
            req_c   = 1'b1;
            rd_c    = 1'b1;
            b_c     = 2'b10;
            waiting = 1'b1;
            if (mem_ready) begin
               ir_c    = 1'b1;
               pc_c    = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            a_c = 2'b01;
            b_c = 2'b01;
            if (opcode == OP_LD || opcode == OP_ST)
               state_d = S_MEMADR;
            else if (opcode == OP_R)
               state_d = S_EXECR;
            else if (opcode == OP_BR && fun3 == 3'b000)
               state_d = S_BEQ;
            else begin
               state_d = S_FAULT;
               fcode_d = 2'b01;
            end
         end
         S_MEMADR: begin
            a_c     = 2'b10;
            b_c     = 2'b01;
            state_d = (opcode == OP_ST) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            req_c   = 1'b1;
            rd_c    = 1'b1;
            iord_c  = 1'b1;
            waiting = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            rw_c    = 1'b1;
            rs_c    = 2'b01;
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_MEMWRITE: begin
            req_c   = 1'b1;
            wr_c    = 1'b1;
            iord_c  = 1'b1;
            waiting = 1'b1;
            if (mem_ready) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end
         end
         S_EXECR: begin
            a_c     = 2'b10;
            op_c    = 2'b10;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            rw_c    = 1'b1;
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_BEQ: begin
            a_c     = 2'b10;
            op_c    = 2'b01;
            br_c    = 1'b1;
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_FAULT: flt_c = 1'b1;
         default: state_d = S_FAULT;
      endcase

      // a completing transfer in the last allowed cycle beats the timeout
      tmo = (TIMEOUT != 0) && waiting && !mem_ready && (wcnt_q == TLIM);
      if (tmo) begin
         state_d = S_FAULT;
         fcode_d = 2'b10;
      end

      if (state_d != state_q)
         wcnt_d = '0;
      else if (waiting && !mem_ready)
         wcnt_d = wcnt_q + 1'b1;
      else
         wcnt_d = wcnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         wcnt_q  <= '0;
         fcode_q <= 2'b00;
         ret_q   <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         fcode_q <= fcode_d;
         if (retire) ret_q <= ret_q + 1'b1;
      end
   end

   // reset forces controls low combinationally so mem_req drops at once
   assign {mem_req, mem_read, mem_write, iord, ir_write, pc_write,
           branch, reg_write, fault, alu_src_a, alu_src_b,
           result_src, ALUop} = rst_n ?
          {req_c, rd_c, wr_c, iord_c, ir_c, pc_c, br_c, rw_c, flt_c,
           a_c, b_c, rs_c, op_c} : 17'd0;

   assign fault_code = fcode_q;
   assign state_out  = state_q;
   assign retired    = ret_q;

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// tb_main_ctrl_fsm: randomized check of main_ctrl_fsm against a
// trace-building instruction model (TIMEOUT=4, CNT_W=4)
module tb_main_ctrl_fsm;
   localparam int TO = 4;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [6:0]    opcode = '0;
   logic [2:0]    fun3 = '0;
   logic          mem_ready = 1'b0;
   logic          mem_req, mem_read, mem_write, iord;
   logic          ir_write, pc_write, branch, reg_write;
   logic [1:0]    alu_src_a, alu_src_b, result_src, ALUop;
   logic          fault;
   logic [1:0]    fault_code;
   logic [3:0]    state_out;
   logic [CW-1:0] retired;

   main_ctrl_fsm #(.TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .fun3(fun3),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_read(mem_read),
      .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
      .pc_write(pc_write), .branch(branch), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .result_src(result_src), .ALUop(ALUop), .fault(fault),
      .fault_code(fault_code), .state_out(state_out),
      .retired(retired)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         st;
      bit         rdy;
      logic [1:0] fc;
      logic [3:0] ret;
   } exp_t;

   exp_t        q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [3:0]  m_ret = '0;
   logic [1:0]  m_fc = '0;
   logic [6:0]  cur_op = '0;
   logic [2:0]  cur_f3 = '0;
   logic [18:0] dut_out;

   assign dut_out = {mem_req, mem_read, mem_write, iord, ir_write,
                     pc_write, branch, reg_write, fault, alu_src_a,
                     alu_src_b, result_src, ALUop, fault_code};

   // expected control vector for one cycle of a given phase
   function automatic logic [18:0] model_out(int st, bit rdy,
                                             logic [1:0] fc);
      logic req, rd, wr, io, ir, pc, br, rw, flt;
      logic [1:0] a, b, rs, op, code;
      {req, rd, wr, io, ir, pc, br, rw, flt} = '0;
      {a, b, rs, op, code} = '0;
      case (st)
         0: begin req = 1; rd = 1; b = 2; ir = rdy; pc = rdy; end
         1: begin a = 1; b = 1; end
         2: begin a = 2; b = 1; end
         3: begin req = 1; rd = 1; io = 1; end
         4: begin rw = 1; rs = 1; end
         5: begin req = 1; wr = 1; io = 1; end
         6: begin a = 2; op = 2; end
         7: rw = 1;
         8: begin a = 2; op = 1; br = 1; end
         15: begin flt = 1; code = fc; end
         default: ;
      endcase
      return {req, rd, wr, io, ir, pc, br, rw, flt, a, b, rs, op, code};
   endfunction

   task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin : cmp
      exp_t e;
      if (q.size() != 0) begin
         e = q.pop_front();
         check("ctrl", 32'(dut_out),
               32'(model_out(e.st, e.rdy, e.fc)));
         check("state", 32'(state_out), 32'(e.st));
         check("retired", 32'(retired), 32'(e.ret));
      end
   end

   function automatic bit rb();
      return 1'($urandom);
   endfunction

   // one clock of a phase; entered and left at posedge+1
   task automatic cyc(int st, bit rdy);
      exp_t e;
      mem_ready = rdy;
      if (st == 0) begin
         opcode = 7'($urandom);
         fun3   = 3'($urandom);
      end else begin
         opcode = cur_op;
         fun3   = cur_f3;
      end
      e.st = st; e.rdy = rdy; e.fc = m_fc; e.ret = m_ret;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      mem_ready = rb();
      #2;
      check("rst_ctrl", 32'(dut_out), 32'd0);
      check("rst_state", 32'(state_out), 32'd0);
      check("rst_retired", 32'(retired), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_ret = '0;
      m_fc  = '0;
   endtask

   task automatic do_fault(logic [1:0] code);
      m_fc = code;
      repeat (3) cyc(15, rb());
      check("fault_lit", 32'({fault, fault_code}), 32'({1'b1, code}));
      do_reset();
   endtask

   // n busy cycles then completion; TO busy cycles in a row is a timeout
   task automatic wait_ph(int st, int n, output bit flt);
      flt = 1'b0;
      for (int i = 0; i < n; i++) begin
         cyc(st, 1'b0);
         if (i == TO - 1) begin
            flt = 1'b1;
            return;
         end
      end
      cyc(st, 1'b1);
   endtask

   // kinds: 0 lw, 1 sw, 2 R, 3 beq, 4 bad opcode, 5 branch fun3!=0
   task automatic run_instr(int kind, int fw, int mw);
      bit flt;
      cur_f3 = 3'($urandom);
      case (kind)
         0: cur_op = 7'b0000011;
         1: cur_op = 7'b0100011;
         2: cur_op = 7'b0110011;
         3: begin cur_op = 7'b1100011; cur_f3 = 3'd0; end
         4: begin
            do cur_op = 7'($urandom);
            while (cur_op inside {7'b0000011, 7'b0100011,
                                  7'b0110011, 7'b1100011});
         end
         default: begin
            cur_op = 7'b1100011;
            cur_f3 = 3'($urandom_range(1, 7));
         end
      endcase
      wait_ph(0, fw, flt);
      if (flt) begin do_fault(2'b10); return; end
      cyc(1, rb());
      case (kind)
         0: begin
            cyc(2, rb());
            wait_ph(3, mw, flt);
            if (flt) begin do_fault(2'b10); return; end
            cyc(4, rb());
         end
         1: begin
            cyc(2, rb());
            wait_ph(5, mw, flt);
            if (flt) begin do_fault(2'b10); return; end
         end
         2: begin cyc(6, rb()); cyc(7, rb()); end
         3: cyc(8, rb());
         default: begin do_fault(2'b01); return; end
      endcase
      m_ret = m_ret + 4'd1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not end");
      $fatal(1);
   end

   initial begin
      int k;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      run_instr(0, 2, 2);
      check("lw_ret_lit", 32'(retired), 32'd1);
      check("lw_fetch_lit", 32'(state_out), 32'd0);
      repeat (15) run_instr(2, 0, 0);
      check("wrap_lit", 32'(retired), 32'd0);
      run_instr(3, 1, 0);
      check("beq_ret_lit", 32'(retired), 32'd1);
      run_instr(2, 3, 0);
      check("late_ready_lit", 32'(retired), 32'd2);
      run_instr(1, 0, 3);
      run_instr(2, 4, 0);
      run_instr(5, 0, 0);
      run_instr(4, 1, 0);
      run_instr(1, 0, 4);
      run_instr(0, 1, 4);

      run_instr(2, 0, 0);
      run_instr(2, 1, 0);
      cur_op = 7'b0000011;
      cyc(0, 1'b1);
      cyc(1, rb());
      cyc(2, rb());
      cyc(3, 1'b0);
      check("pre_rst_req_lit", 32'(mem_req), 32'd1);
      do_reset();
      run_instr(0, 0, 0);

      repeat (120) begin
         k = $urandom_range(0, 11);
         run_instr(k < 10 ? k % 4 : (k == 10 ? 4 : 5),
                   $urandom_range(0, 3), $urandom_range(0, 3));
      end

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
